mux_4_32_arb: RTL and testbench
===============================

MUX_4_32_ARB -- requirements
Module: mux_4_32_arb

Interface
REQ-001 The block SHALL have parameter: BURST_LEN, 4, maximum accepted beats per grant (legal 1..16).
REQ-002 The block SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port: req  input  4  per-requester request, bit i = requester i, level-held.
REQ-005 The block SHALL have ports: data_3, data_2, data_1, data_0  input  32 each  requester payloads.
REQ-006 The block SHALL have port: out_ready  input  1  downstream accepts beat when high.
REQ-007 The block SHALL have port: grant  output  4  one-hot current owner, 0 when idle.
REQ-008 The block SHALL have port: sel  output  2  index of current owner, 0 when idle.
REQ-009 The block SHALL have port: out_valid  output  1  beat presented on out_data.
REQ-010 The block SHALL have port: out_last  output  1  final beat of current grant.
REQ-011 The block SHALL have port: out_data  output  32  selected payload.

Function
REQ-012 The block SHALL implement two states, IDLE and BUSY, held in a registered FSM.
REQ-013 In IDLE, grant, sel, out_valid and out_last SHALL be 0.
REQ-014 In IDLE with req!=0 at a rising edge, the block SHALL enter BUSY and grant the first set req bit searching upward from rr_ptr with wrap 3->0; grant visible one cycle after req sampled.
REQ-015 In IDLE with req==0, the block SHALL remain in IDLE.
REQ-016 In BUSY, out_valid SHALL equal req[sel], and out_data SHALL be combinationally data_<sel> (no register stage).
REQ-017 A beat SHALL be accepted when out_valid && out_ready on a rising edge; the beat counter (5 bits, reset 0) increments on each accept.
REQ-018 out_last SHALL be high when out_valid is high and beat counter == BURST_LEN-1.
REQ-019 The grant SHALL release on the edge where a beat with out_last is accepted, or on any BUSY edge where req[sel] is low.
REQ-020 On release, the block SHALL set rr_ptr = (sel+1) mod 4, clear the beat counter and return to IDLE; one idle bubble cycle SHALL separate consecutive grants.
REQ-021 Requests arriving during BUSY SHALL be held off and not affect the current grant.
REQ-022 Simultaneous requests SHALL be resolved solely by rr_ptr order; no requester SHALL wait more than 3 grants.
REQ-023 out_valid low with out_ready high SHALL not advance the beat counter.
REQ-024 With BURST_LEN=1, out_last SHALL be high on every valid beat.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously force state IDLE, rr_ptr 0, beat counter 0, grant 0, sel 0, out_valid 0, out_last 0.
REQ-026 Reset asserted mid-burst SHALL abort the grant with no further beat accepted; after release, arbitration SHALL restart from requester 0.

Configuration
REQ-027 The macro MUX_ARB_TRISTATE_EN SHALL, when defined, drive out_data to 32'bz whenever out_valid is low.
REQ-028 Without MUX_ARB_TRISTATE_EN, out_data SHALL be 32'h0 whenever out_valid is low.

Verification
REQ-029 The bench SHALL cover: reset, req=4'b0001, out_ready=1, BURST_LEN=4 -> grant 0001 one cycle later, 4 beats of data_0, out_last on 4th, then IDLE bubble.
REQ-030 The bench SHALL cover: req=4'b1111 held, out_ready=1 -> grant order 0001,0010,0100,1000,0001 with 4 beats each and one bubble between.
REQ-031 The bench SHALL cover: grant on requester 2, out_ready=0 for 3 cycles then 1 -> counter frozen while stalled, out_data=data_2 throughout, 4 beats total.
REQ-032 The bench SHALL cover: requester 1 drops req after 2 beats -> release next edge, rr_ptr=2, requester 3 (only other req) granted after bubble.
REQ-033 The bench SHALL cover: rst_n pulsed low mid-burst on requester 3 -> all outputs 0 immediately; next req=4'b1010 grants requester 1.
REQ-034 The bench SHALL cover: idle with MUX_ARB_TRISTATE_EN defined -> out_data=32'bz; undefined -> out_data=32'h0.

Source files
------------

// File: rtl/mux_4_32_arb.sv
// Round-robin 4:1 burst arbiter/mux for 32-bit payloads; owner keeps the bus for up to BURST_LEN beats.
// Optional macro MUX_ARB_TRISTATE_EN floats out_data whenever no beat is presented.
module mux_4_32_arb #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data_3,
  input  logic [31:0] data_2,
  input  logic [31:0] data_1,
  input  logic [31:0] data_0,
  input  logic        out_ready,
  output logic [3:0]  grant,
  output logic [1:0]  sel,
  output logic        out_valid,
  output logic        out_last,
  output logic [31:0] out_data
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic [4:0]  beat_q, beat_d;
  logic [1:0]  pick;
  logic        pick_vld;
  logic [31:0] data_sel;
  logic        accept;
  logic        release_now;

  // First set request at or above rr_ptr, wrapping 3 -> 0.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    case (owner_q)
      2'd0:    data_sel = data_0;
      2'd1:    data_sel = data_1;
      2'd2:    data_sel = data_2;
      default: data_sel = data_3;
    endcase
  end

  always_comb begin
    grant     = '0;
    sel       = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (state_q == BUSY) begin
      grant     = 4'b0001 << owner_q;
      sel       = owner_q;
      out_valid = req[owner_q];
      out_last  = req[owner_q] && (beat_q == 5'(BURST_LEN - 1));
    end
  end

`ifdef MUX_ARB_TRISTATE_EN
  assign out_data = out_valid ? data_sel : 'z;
`else
  assign out_data = out_valid ? data_sel : '0;
`endif

  assign accept      = out_valid && out_ready;
  assign release_now = (state_q == BUSY) && (!req[owner_q] || (accept && out_last));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          owner_d = pick;
          beat_d  = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + 2'd1;
          owner_d  = '0;
          beat_d   = '0;
        end else if (accept) begin
          beat_d = beat_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_mux_4_32_arb.sv
// Directed bench for mux_4_32_arb (BURST_LEN=4); expected values are hand-derived per cycle.
module tb_mux_4_32_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data_3 = 32'hD3D3_0003;
  logic [31:0] data_2 = 32'hD2D2_0002;
  logic [31:0] data_1 = 32'hD1D1_0001;
  logic [31:0] data_0 = 32'hD0D0_0000;
  logic        out_ready = 1'b0;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_last;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

`ifdef MUX_ARB_TRISTATE_EN
  localparam logic [31:0] IDLE_DATA = 32'bz;
`else
  localparam logic [31:0] IDLE_DATA = 32'h0;
`endif

  mux_4_32_arb #(.BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data_3(data_3), .data_2(data_2), .data_1(data_1), .data_0(data_0),
    .out_ready(out_ready), .grant(grant), .sel(sel),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] payload(input int unsigned idx);
    case (idx)
      0:       return 32'hD0D0_0000;
      1:       return 32'hD1D1_0001;
      2:       return 32'hD2D2_0002;
      default: return 32'hD3D3_0003;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, 32'(grant), 32'h0);
    check({tag, ".sel"}, 32'(sel), 32'h0);
    check({tag, ".valid"}, 32'(out_valid), 32'h0);
    check({tag, ".last"}, 32'(out_last), 32'h0);
    check({tag, ".data"}, out_data, IDLE_DATA);
  endtask

  task automatic check_beat(input string tag, input int unsigned idx, input logic last);
    check({tag, ".grant"}, 32'(grant), 32'(4'b0001 << idx));
    check({tag, ".sel"}, 32'(sel), idx);
    check({tag, ".valid"}, 32'(out_valid), 32'h1);
    check({tag, ".last"}, 32'(out_last), 32'(last));
    check({tag, ".data"}, out_data, payload(idx));
  endtask

  // Entered at the negedge where the grant is first visible; leaves at the bubble negedge.
  task automatic burst(input string tag, input int unsigned idx);
    for (int b = 0; b < 4; b++) begin
      #1 check_beat($sformatf("%s.b%0d", tag, b), idx, b == 3);
      @(negedge clk);
    end
    #1 check_idle({tag, ".bubble"});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    // Single requester, full burst then bubble
    do_reset();
    req = 4'b0001; out_ready = 1'b1;
    #1 check_idle("s1.pre");
    @(negedge clk);
    burst("s1", 0);
    req = '0;
    @(negedge clk);
    #1 check_idle("s1.idle");

    // All requesting: round-robin order 0,1,2,3,0
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    burst("s2.g0", 0); @(negedge clk);
    burst("s2.g1", 1); @(negedge clk);
    burst("s2.g2", 2); @(negedge clk);
    burst("s2.g3", 3); @(negedge clk);
    burst("s2.g0b", 0);
    req = '0;

    // Stall on requester 2: counter must not advance
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      #1 check_beat($sformatf("s3.stall%0d", s), 2, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    burst("s3", 2);
    req = '0;

    // Requester 1 drops after 2 beats; requester 3 next
    do_reset();
    req = 4'b1010; out_ready = 1'b1;
    @(negedge clk);
    #1 check_beat("s4.b0", 1, 1'b0);
    @(negedge clk);
    #1 check_beat("s4.b1", 1, 1'b0);
    @(negedge clk);
    req = 4'b1000;
    #1 check("s4.drop.grant", 32'(grant), 32'h2);
    check("s4.drop.valid", 32'(out_valid), 32'h0);
    check("s4.drop.data", out_data, IDLE_DATA);
    @(negedge clk);
    #1 check_idle("s4.bubble");
    @(negedge clk);
    burst("s4.r3", 3);
    req = '0;

    // Reset mid-burst on requester 3, with rr_ptr moved off 0 first
    do_reset();
    req = 4'b0100; out_ready = 1'b1;
    @(negedge clk);
    burst("s5.r2", 2);
    req = 4'b1000;
    @(negedge clk);
    #1 check_beat("s5.b0", 3, 1'b0);
    @(negedge clk);
    #1 check_beat("s5.b1", 3, 1'b0);
    rst_n = 1'b0;
    #1 check_idle("s5.async");
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1010;
    #1 check_idle("s5.post");
    @(negedge clk);
    #1 check_beat("s5.restart", 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
